// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory-unit arbiter: FSM encoding,
// transfer-length codes and IO address decode.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } grant_t;

  localparam logic [2:0] LEN_B = 3'b000;
  localparam logic [2:0] LEN_H = 3'b001;
  localparam logic [2:0] LEN_W = 3'b010;
  localparam int         LEN_UNSIGNED_BIT = 2;

  localparam logic [1:0] IO_HI_BITS_DEF = 2'b11;

  function automatic logic is_io_addr(input logic [31:0] addr, input logic [1:0] hi_bits);
    return (addr[17:16] == hi_bits);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto a single memory
// unit; one transfer in flight, round-robin on ties, ifetch cancel via flush.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_HI_BITS = IO_HI_BITS_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_valid,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_data,
  input  logic        flush,
  input  logic        ls_valid,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [2:0]  ls_len,
  input  logic [31:0] ls_data,
  output logic        ls_ready,
  output logic [31:0] ls_data_out,
  input  logic        io_buffer_full,
  output logic        mu_valid,
  output logic        mu_wr,
  output logic [31:0] mu_addr,
  output logic [2:0]  mu_len,
  output logic [31:0] mu_data,
  input  logic        mu_ready,
  input  logic [31:0] mu_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  grant_t      r_last_grant;
  logic        r_drop;
  logic        r_mu_valid;
  logic        r_mu_wr;
  logic [31:0] r_mu_addr;
  logic [2:0]  r_mu_len;
  logic [31:0] r_mu_data;
  logic [31:0] r_if_data;
  logic [31:0] r_ls_data;

  logic        w_if_req;
  logic        w_io_wr;
  logic        w_ls_req;
  logic        w_gnt_if;
  logic        w_gnt_ls;
  logic        w_complete;
  logic        w_flush_eff;

  // A flushed fetch is never granted; an IO store waits while the UART is full.
  assign w_if_req    = if_valid && !flush;
  assign w_io_wr     = ls_valid && ls_wr && is_io_addr(ls_addr, IO_HI_BITS);
  assign w_ls_req    = ls_valid && !(w_io_wr && io_buffer_full);
  assign w_flush_eff = flush && rdy_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_if    = 1'b0;
    w_gnt_ls    = 1'b0;
    w_complete  = 1'b0;
    if_ready    = 1'b0;
    ls_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ls_req && (!w_if_req || r_last_grant == GNT_IF)) begin
          w_gnt_ls    = 1'b1;
          w_state_nxt = ST_BUSY_LS;
        end else if (w_if_req) begin
          w_gnt_if    = 1'b1;
          w_state_nxt = ST_BUSY_IF;
        end
      end
      ST_BUSY_IF, ST_BUSY_LS: begin
        if (mu_ready) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (r_last_grant == GNT_IF) begin
          if_ready = !r_drop && !w_flush_eff;
        end else begin
          ls_ready = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_last_grant <= GNT_IF;
      r_drop       <= 1'b0;
      r_mu_valid   <= 1'b0;
      r_mu_wr      <= 1'b0;
      r_mu_addr    <= '0;
      r_mu_len     <= '0;
      r_mu_data    <= '0;
      r_if_data    <= '0;
      r_ls_data    <= '0;
    end else if (rdy_in) begin
      if (w_gnt_if) begin
        r_mu_valid   <= 1'b1;
        r_mu_wr      <= 1'b0;
        r_mu_addr    <= if_addr;
        r_mu_len     <= LEN_W;
        r_mu_data    <= '0;
        r_last_grant <= GNT_IF;
      end else if (w_gnt_ls) begin
        r_mu_valid   <= 1'b1;
        r_mu_wr      <= ls_wr;
        r_mu_addr    <= ls_addr;
        r_mu_len     <= ls_len;
        r_mu_data    <= ls_data;
        r_last_grant <= GNT_LS;
      end

      // A fetch flushed at any point of its transfer completes silently.
      if (w_complete) begin
        r_mu_valid <= 1'b0;
        if (r_state == ST_BUSY_IF && !(r_drop || flush)) begin
          r_if_data <= mu_rdata;
        end
        if (r_state == ST_BUSY_LS && !r_mu_wr) begin
          r_ls_data <= mu_rdata;
        end
      end

      if (r_state == ST_BUSY_IF && flush) begin
        r_drop <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_drop <= 1'b0;
      end
    end
  end

  assign mu_valid    = r_mu_valid;
  assign mu_wr       = r_mu_wr;
  assign mu_addr     = r_mu_addr;
  assign mu_len      = r_mu_len;
  assign mu_data     = r_mu_data;
  assign if_data     = r_if_data;
  assign ls_data_out = r_ls_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory unit that
// answers mu_ready a programmable number of cycles after mu_valid.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_data;
  logic        flush = 1'b0;
  logic        ls_valid = 1'b0;
  logic        ls_wr = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [2:0]  ls_len = '0;
  logic [31:0] ls_data = '0;
  logic        ls_ready;
  logic [31:0] ls_data_out;
  logic        io_buffer_full = 1'b0;
  logic        mu_valid;
  logic        mu_wr;
  logic [31:0] mu_addr;
  logic [2:0]  mu_len;
  logic [31:0] mu_data;
  logic        mu_ready = 1'b0;
  logic [31:0] mu_rdata = '0;

  int          total = 0;
  int          bad = 0;
  int          mem_lat = 4;
  int          mem_cnt = 0;
  logic        mem_fixed = 1'b0;
  logic [31:0] mem_data = '0;

  mem_arbiter #(.IO_HI_BITS(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .flush(flush),
    .ls_valid(ls_valid), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
    .ls_data(ls_data), .ls_ready(ls_ready), .ls_data_out(ls_data_out),
    .io_buffer_full(io_buffer_full),
    .mu_valid(mu_valid), .mu_wr(mu_wr), .mu_addr(mu_addr), .mu_len(mu_len),
    .mu_data(mu_data), .mu_ready(mu_ready), .mu_rdata(mu_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Memory unit: read data is the address XOR a pattern unless a fixed word is chosen.
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (rst_in) begin
        mu_ready = 1'b0; mu_rdata = '0; mem_cnt = 0;
      end else if (rdy_in) begin
        if (mu_ready) begin
          mu_ready = 1'b0; mu_rdata = '0; mem_cnt = 0;
        end else if (mu_valid) begin
          mem_cnt++;
          if (mem_cnt > mem_lat) begin
            mu_ready = 1'b1;
            mu_rdata = mem_fixed ? mem_data : (mu_addr ^ 32'hA5A5_A5A5);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1;
    cyc(); cyc();
    total++;
    if ({mu_valid, mu_wr, mu_len, if_ready, ls_ready} !== 7'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0", {mu_valid, mu_wr, mu_len, if_ready, ls_ready});
    end
    total++;
    if (mu_addr !== 32'h0) begin bad++; $display("FAIL reset_mu_addr got=%h exp=0", mu_addr); end
    total++;
    if (mu_data !== 32'h0) begin bad++; $display("FAIL reset_mu_data got=%h exp=0", mu_data); end
    total++;
    if (if_data !== 32'h0) begin bad++; $display("FAIL reset_if_data got=%h exp=0", if_data); end
    total++;
    if (ls_data_out !== 32'h0) begin bad++; $display("FAIL reset_ls_data got=%h exp=0", ls_data_out); end
    rst_in = 1'b0;
    cyc();
    total++;
    if (mu_valid !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=0", mu_valid); end
  endtask

  task automatic test_ifetch();
    int lat;
    int unstable;
    lat = 0; unstable = 0;
    mem_fixed = 1'b1; mem_data = 32'hDEAD_BEEF; mem_lat = 4;
    if_valid = 1'b1; if_addr = 32'h0000_1000;
    cyc();
    total++;
    if ({mu_valid, mu_wr, mu_len} !== 5'b1_0_010) begin
      bad++; $display("FAIL if_grant_ctrl got=%b exp=10010", {mu_valid, mu_wr, mu_len});
    end
    total++;
    if (mu_addr !== 32'h0000_1000 || mu_data !== 32'h0) begin
      bad++; $display("FAIL if_grant_payload got=%h/%h exp=00001000/00000000", mu_addr, mu_data);
    end
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (mu_valid && (mu_addr !== 32'h0000_1000 || mu_len !== 3'b010 || mu_wr !== 1'b0)) unstable++;
      if (if_ready) begin lat = i; break; end
    end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL if_latency got=%0d exp=5", lat); end
    total++;
    if (unstable !== 0) begin bad++; $display("FAIL if_mu_stable got=%0d exp=0", unstable); end
    total++;
    if (if_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL if_data got=%h exp=deadbeef", if_data); end
    if_valid = 1'b0;
    cyc();
    total++;
    if ({if_ready, mu_valid} !== 2'b00 || if_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL if_after_done got=%b %h exp=00 deadbeef", {if_ready, mu_valid}, if_data);
    end
    mem_fixed = 1'b0;
  endtask

  task automatic test_tie();
    int evt[4];
    int nevt;
    int extra;
    nevt = 0; extra = 0;
    for (int k = 0; k < 4; k++) evt[k] = 0;
    rst_in = 1'b1; cyc(); rst_in = 1'b0;
    mem_lat = 1;
    if_valid = 1'b1; if_addr = 32'h0000_2000;
    ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h0000_0100; ls_len = 3'b010;
    cyc();
    total++;
    if (mu_addr !== 32'h0000_0100 || mu_valid !== 1'b1) begin
      bad++; $display("FAIL tie_first_ls got=%h exp=00000100", mu_addr);
    end
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (ls_ready) begin if (nevt < 4) evt[nevt] = 2; nevt++; ls_valid = 1'b0; end
      if (if_ready) begin if (nevt < 4) evt[nevt] = 1; nevt++; if_valid = 1'b0; end
      if (!if_valid && !ls_valid) break;
    end
    repeat (5) begin
      cyc();
      if (if_ready || ls_ready) extra++;
    end
    total++;
    if (nevt !== 2 || evt[0] !== 2 || evt[1] !== 1) begin
      bad++; $display("FAIL tie_order got=%0d:%0d,%0d exp=2:2,1", nevt, evt[0], evt[1]);
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL tie_extra_pulse got=%0d exp=0", extra); end
    total++;
    if (ls_data_out !== 32'hA5A5_A4A5) begin bad++; $display("FAIL tie_ls_data got=%h exp=a5a5a4a5", ls_data_out); end
    total++;
    if (if_data !== 32'hA5A5_85A5) begin bad++; $display("FAIL tie_if_data got=%h exp=a5a585a5", if_data); end
  endtask

  task automatic test_io_full();
    int granted;
    logic got;
    granted = 0; got = 1'b0;
    io_buffer_full = 1'b1;
    ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h0003_0000; ls_len = 3'b000; ls_data = 32'h41;
    repeat (5) begin
      cyc();
      if (mu_valid) granted++;
    end
    total++;
    if (granted !== 0) begin bad++; $display("FAIL io_blocked got=%0d exp=0", granted); end
    io_buffer_full = 1'b0;
    cyc();
    total++;
    if ({mu_valid, mu_wr, mu_len} !== 5'b1_1_000) begin
      bad++; $display("FAIL io_grant_ctrl got=%b exp=11000", {mu_valid, mu_wr, mu_len});
    end
    total++;
    if (mu_data !== 32'h41 || mu_addr !== 32'h0003_0000) begin
      bad++; $display("FAIL io_grant_payload got=%h/%h exp=00000041/00030000", mu_data, mu_addr);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ls_ready) begin got = 1'b1; break; end
    end
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL io_ready got=%b exp=1", got); end
    total++;
    if (ls_data_out !== 32'hA5A5_A4A5) begin bad++; $display("FAIL io_wr_keeps_data got=%h exp=a5a5a4a5", ls_data_out); end
    ls_valid = 1'b0;
    cyc();
    // A non-IO store is not held back by a full UART buffer.
    io_buffer_full = 1'b1;
    ls_valid = 1'b1; ls_wr = 1'b1; ls_addr = 32'h0002_0004; ls_len = 3'b001; ls_data = 32'h5A;
    cyc();
    total++;
    if (mu_valid !== 1'b1 || mu_addr !== 32'h0002_0004) begin
      bad++; $display("FAIL mem_wr_not_blocked got=%b/%h exp=1/00020004", mu_valid, mu_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ls_ready) begin got = 1'b1; break; end
    end
    ls_valid = 1'b0; io_buffer_full = 1'b0;
    cyc();
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL mem_wr_ready got=%b exp=1", got); end
  endtask

  task automatic test_flush();
    logic [31:0] prev_if;
    int n_if;
    logic got_ls;
    prev_if = if_data; n_if = 0; got_ls = 1'b0;
    mem_lat = 4;
    if_valid = 1'b1; if_addr = 32'h0000_3000;
    ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h0000_0400; ls_len = 3'b010;
    cyc();
    total++;
    if (mu_addr !== 32'h0000_3000 || mu_valid !== 1'b1) begin
      bad++; $display("FAIL flush_if_granted got=%h exp=00003000", mu_addr);
    end
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; if_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (if_ready) n_if++;
      if (ls_ready) begin got_ls = 1'b1; ls_valid = 1'b0; break; end
    end
    total++;
    if (n_if !== 0) begin bad++; $display("FAIL flush_no_if_ready got=%0d exp=0", n_if); end
    total++;
    if (if_data !== prev_if) begin bad++; $display("FAIL flush_if_data got=%h exp=%h", if_data, prev_if); end
    total++;
    if (got_ls !== 1'b1 || ls_data_out !== 32'hA5A5_A1A5) begin
      bad++; $display("FAIL flush_ls_served got=%b/%h exp=1/a5a5a1a5", got_ls, ls_data_out);
    end
    cyc();
  endtask

  task automatic test_flush_idle();
    logic got;
    got = 1'b0;
    if_valid = 1'b1; if_addr = 32'h0000_4000; flush = 1'b1;
    cyc();
    total++;
    if (mu_valid !== 1'b0) begin bad++; $display("FAIL flush_idle_nogrant got=%b exp=0", mu_valid); end
    flush = 1'b0;
    cyc();
    total++;
    if (mu_valid !== 1'b1 || mu_addr !== 32'h0000_4000) begin
      bad++; $display("FAIL flush_idle_regrant got=%b/%h exp=1/00004000", mu_valid, mu_addr);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (if_ready) begin got = 1'b1; break; end
    end
    if_valid = 1'b0;
    total++;
    if (got !== 1'b1 || if_data !== 32'hA5A5_E5A5) begin
      bad++; $display("FAIL flush_idle_data got=%b/%h exp=1/a5a5e5a5", got, if_data);
    end
    cyc();
  endtask

  task automatic test_freeze();
    logic [66:0] snap;
    int frozen_bad;
    int lat;
    frozen_bad = 0; lat = 0;
    mem_lat = 4;
    ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h0000_0500; ls_len = 3'b010;
    cyc();
    cyc();
    rdy_in = 1'b0;
    snap = {mu_valid, mu_addr, ls_ready, if_ready, ls_data_out};
    repeat (3) begin
      cyc();
      if ({mu_valid, mu_addr, ls_ready, if_ready, ls_data_out} !== snap) frozen_bad++;
    end
    rdy_in = 1'b1;
    total++;
    if (frozen_bad !== 0 || snap[66] !== 1'b1) begin
      bad++; $display("FAIL freeze_outputs got=%0d exp=0", frozen_bad);
    end
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (ls_ready) begin lat = i; break; end
    end
    ls_valid = 1'b0;
    total++;
    if (lat !== 4) begin bad++; $display("FAIL freeze_latency got=%0d exp=4", lat); end
    total++;
    if (ls_data_out !== 32'hA5A5_A0A5) begin bad++; $display("FAIL freeze_ls_data got=%h exp=a5a5a0a5", ls_data_out); end
    cyc();
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    mem_lat = 4;
    ls_valid = 1'b1; ls_wr = 1'b0; ls_addr = 32'h0000_0600; ls_len = 3'b010;
    cyc();
    total++;
    if (mu_valid !== 1'b1) begin bad++; $display("FAIL rstmid_started got=%b exp=1", mu_valid); end
    cyc();
    rst_in = 1'b1; ls_valid = 1'b0;
    cyc();
    rst_in = 1'b0;
    total++;
    if ({mu_valid, ls_ready} !== 2'b00 || mu_addr !== 32'h0) begin
      bad++; $display("FAIL rstmid_idle got=%b/%h exp=00/00000000", {mu_valid, ls_ready}, mu_addr);
    end
    repeat (10) begin
      cyc();
      if (ls_ready || mu_valid) n++;
    end
    total++;
    if (n !== 0) begin bad++; $display("FAIL rstmid_no_ready got=%0d exp=0", n); end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_tie();
    test_io_full();
    test_flush();
    test_freeze();
    test_reset_mid();
    test_flush_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
